// File: rtl/ula_vram_scheduler.sv
// ula_vram_scheduler
//   Time-slot arbiter for the single-port screen VRAM. Each 8-pixel cell spends phases 0 and 1
//   on display fetches (bitmap, then attribute). The CPU gets the remaining slots, one access
//   per two clocks.
//   Every action tied to a phase happens on the clock edge that samples that phase in i_hc.
//   The registered outputs show the result in the following cycle. i_vram_din is read one
//   clock after o_vram_addr is registered.
// Ports
//   i_clk, i_rst            pixel clock, asynchronous active-high reset
//   i_hc, i_vc              beam counters from the sync generator
//   i_screen_page           screen page, becomes o_vram_addr[13]
//   i_cpu_req/we/addr/din   CPU request, held until o_cpu_ack
//   o_cpu_dout, o_cpu_ack   read data and one-cycle completion pulse
//   o_cpu_wait              combinational contention stall
//   o_vram_addr/we/dout     VRAM address, write strobe and write data
//   i_vram_din              VRAM read data
//   o_bitmap_byte/attr_byte latched display bytes for the current cell
//   o_pix_load              strobe: new bitmap/attribute pair valid
module ula_vram_scheduler #(
  parameter int unsigned HACTIVE   = 256,
  parameter int unsigned VACTIVE   = 192,
  parameter logic [12:0] ATTR_BASE = 13'h1800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_hc,
  input  logic [8:0]  i_vc,
  input  logic        i_screen_page,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [12:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_din,
  output logic [7:0]  o_cpu_dout,
  output logic        o_cpu_ack,
  output logic        o_cpu_wait,
  output logic [13:0] o_vram_addr,
  output logic        o_vram_we,
  output logic [7:0]  o_vram_dout,
  input  logic [7:0]  i_vram_din,
  output logic [7:0]  o_bitmap_byte,
  output logic [7:0]  o_attr_byte,
  output logic        o_pix_load
);

  localparam logic [9:0] HActW = 10'(HACTIVE);
  localparam logic [9:0] VActW = 10'(VACTIVE);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e      r_state;
  logic [7:0]  r_cpu_dout;
  logic        r_cpu_ack;
  logic [13:0] r_vram_addr;
  logic        r_vram_we;
  logic [7:0]  r_vram_dout;
  logic [7:0]  r_bitmap_byte;
  logic [7:0]  r_attr_byte;
  logic        r_pix_load;

  logic [2:0]  w_phase;
  logic [4:0]  w_col;
  logic        w_win;
  logic        w_disp_slot;
  logic        w_grant;
  logic [13:0] w_bmp_addr;
  logic [13:0] w_attr_addr;

  assign w_phase     = i_hc[2:0];
  assign w_col       = i_hc[7:3];
  assign w_win       = ({1'b0, i_hc} < HActW) && ({1'b0, i_vc} < VActW);
  assign w_disp_slot = w_win && ((w_phase == 3'd0) || (w_phase == 3'd1));
  assign w_grant     = (r_state == StIdle) && !w_disp_slot;
  assign o_cpu_wait  = i_cpu_req & ~w_grant;

  // Bitmap rows are interleaved: third of screen, pixel row in char, char row.
  assign w_bmp_addr  = {i_screen_page, i_vc[7:6], i_vc[2:0], i_vc[5:3], w_col};
  assign w_attr_addr = {i_screen_page, ATTR_BASE | {3'b000, i_vc[7:3], w_col}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_cpu_dout    <= 8'h00;
      r_cpu_ack     <= 1'b0;
      r_vram_addr   <= 14'h0000;
      r_vram_we     <= 1'b0;
      r_vram_dout   <= 8'h00;
      r_bitmap_byte <= 8'h00;
      r_attr_byte   <= 8'h00;
      r_pix_load    <= 1'b0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_pix_load <= w_win && (w_phase == 3'd3);

      case (r_state)
        StIdle: begin
          if (i_cpu_req && w_grant) begin
            r_vram_addr <= {i_screen_page, i_cpu_addr};
            r_vram_we   <= i_cpu_we;
            r_vram_dout <= i_cpu_din;
            r_state     <= StData;
          end
        end
        StData: begin
          r_cpu_ack <= 1'b1;
          // r_vram_we still holds the direction of the access completing now.
          if (!r_vram_we) r_cpu_dout <= i_vram_din;
          r_vram_we <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      // Display slots come last so they own the address port at phases 0/1. A CPU access
      // issued at phase 7 completes at phase 0 and takes its data before the address changes.
      if (w_win) begin
        unique case (w_phase)
          3'd0: begin
            r_vram_addr <= w_bmp_addr;
            r_vram_we   <= 1'b0;
          end
          3'd1: begin
            r_bitmap_byte <= i_vram_din;
            r_vram_addr   <= w_attr_addr;
          end
          3'd2: r_attr_byte <= i_vram_din;
          default: ;
        endcase
      end
    end
  end

  assign o_cpu_dout    = r_cpu_dout;
  assign o_cpu_ack     = r_cpu_ack;
  assign o_vram_addr   = r_vram_addr;
  assign o_vram_we     = r_vram_we;
  assign o_vram_dout   = r_vram_dout;
  assign o_bitmap_byte = r_bitmap_byte;
  assign o_attr_byte   = r_attr_byte;
  assign o_pix_load    = r_pix_load;

endmodule

// File: tb/tb_ula_vram_scheduler.sv
// Bench for ula_vram_scheduler: drives the beam counters, models the synchronous VRAM, and
// scoreboards CPU read data and display byte pairs against a shadow copy of memory.
module tb_ula_vram_scheduler;

  localparam int unsigned HTOTAL = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic        page;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din;
  logic [7:0]  bitmap_byte;
  logic [7:0]  attr_byte;
  logic        pix_load;

  ula_vram_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_hc          (hc),
    .i_vc          (vc),
    .i_screen_page (page),
    .i_cpu_req     (cpu_req),
    .i_cpu_we      (cpu_we),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_din     (cpu_din),
    .o_cpu_dout    (cpu_dout),
    .o_cpu_ack     (cpu_ack),
    .o_cpu_wait    (cpu_wait),
    .o_vram_addr   (vram_addr),
    .o_vram_we     (vram_we),
    .o_vram_dout   (vram_dout),
    .i_vram_din    (vram_din),
    .o_bitmap_byte (bitmap_byte),
    .o_attr_byte   (attr_byte),
    .o_pix_load    (pix_load)
  );

  always #5 clk = ~clk;

  // VRAM: the DUT's registered address is the RAM address register, so data follows it.
  logic [7:0]  ram   [16384];
  logic [7:0]  model [16384];
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr;
  logic [7:0]  bd_data;

  assign vram_din = ram[vram_addr];

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (vram_we) ram[vram_addr] <= vram_dout;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_pix    = 0;
  int n_acks   = 0;

  logic [8:0]  last_hc;
  logic        ack_seen;
  logic [8:0]  ack_hc;
  logic [8:0]  cpu_q [$];   // {is_read, expected data}
  logic [15:0] pix_q [$];   // {bitmap, attr}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic win_f(input logic [8:0] h, input logic [8:0] v);
    return (int'(h) < 256) && (int'(v) < 192);
  endfunction

  function automatic logic [13:0] bmp_addr_f(input logic p, input logic [8:0] h,
                                             input logic [8:0] v);
    return {p, v[7:6], v[2:0], v[5:3], h[7:3]};
  endfunction

  function automatic logic [13:0] attr_addr_f(input logic p, input logic [8:0] h,
                                              input logic [8:0] v);
    return {p, 3'b110, v[7:3], h[7:3]};
  endfunction

  task automatic observe();
    logic [15:0] e_pix;
    logic [8:0]  e_cpu;
    if (pix_load === 1'b1) begin
      n_pix++;
      check("pix_phase", 32'(last_hc[2:0]), 32'd3);
      if (pix_q.size() == 0) check("pix_unexpected", 32'd1, 32'd0);
      else begin
        e_pix = pix_q.pop_front();
        check("bitmap_byte", 32'(bitmap_byte), 32'(e_pix[15:8]));
        check("attr_byte", 32'(attr_byte), 32'(e_pix[7:0]));
      end
    end
    if (cpu_ack === 1'b1) begin
      n_acks++;
      ack_seen = 1'b1;
      ack_hc   = last_hc;
      if (cpu_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else begin
        e_cpu = cpu_q.pop_front();
        if (e_cpu[8]) check("cpu_dout", 32'(cpu_dout), 32'(e_cpu[7:0]));
      end
    end
  endtask

  // One clock: queue the display pair for a cell fetched at this edge, then sample the
  // results 1 ns after the edge and advance the beam.
  task automatic tick();
    if (!rst && win_f(hc, vc) && hc[2:0] == 3'd0)
      pix_q.push_back({model[bmp_addr_f(page, hc, vc)], model[attr_addr_f(page, hc, vc)]});
    @(posedge clk);
    #1;
    last_hc = hc;
    observe();
    hc = (hc == 9'(HTOTAL - 1)) ? 9'd0 : hc + 9'd1;
    #1;
    if (vram_we === 1'b1)
      check("we_in_display_slot", 32'(win_f(hc, vc) && hc[2:0] < 3'd2), 32'd0);
  endtask

  task automatic bd_write(input logic [13:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    model[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  // One CPU access, held until acknowledged. Checks stall length and issue/ack timing.
  task automatic cpu_access(input logic w, input logic [12:0] a, input logic [7:0] d);
    logic [8:0] start_hc, exp_issue, issue_hc;
    logic       issued;
    int         stalls;
    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_din = d;
    if (w) begin
      model[{page, a}] = d;
      cpu_q.push_back({1'b0, d});
    end else cpu_q.push_back({1'b1, model[{page, a}]});
    #1;
    start_hc  = hc;
    exp_issue = hc;
    while (win_f(exp_issue, vc) && exp_issue[2:0] < 3'd2) exp_issue = exp_issue + 9'd1;
    issued = 1'b0; issue_hc = 9'd0; stalls = 0; ack_seen = 1'b0;
    for (int k = 0; k < 20 && !ack_seen; k++) begin
      if (!issued) begin
        if (cpu_wait) stalls++;
        else begin
          issued   = 1'b1;
          issue_hc = hc;
        end
      end
      tick();
    end
    cpu_req = 1'b0;
    check("ack_seen", 32'(ack_seen), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_issue - start_hc));
    check("issue_hc", 32'(issue_hc), 32'(exp_issue));
    check("ack_hc", 32'(ack_hc), 32'(issue_hc + 9'd1));
  endtask

  initial begin
    int pix_before;
    int acks_before;
    int k;
    hc = 9'd100; vc = 9'd50; page = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0; cpu_din = 8'h00;
    for (int i = 0; i < 16384; i++) model[i] = 8'h00;

    // Reset mid-frame.
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_vram_we", 32'(vram_we), 32'd0);
    check("rst_vram_dout", 32'(vram_dout), 32'd0);
    check("rst_bitmap", 32'(bitmap_byte), 32'd0);
    check("rst_attr", 32'(attr_byte), 32'd0);
    check("rst_pix_load", 32'(pix_load), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);

    // Preload line 0 of both pages plus a few CPU locations while held in reset.
    for (int c = 0; c < 32; c++) begin
      bd_write(14'h0000 + 14'(c), (c == 0) ? 8'hAA : 8'(c * 7 + 1));
      bd_write(14'h1800 + 14'(c), (c == 0) ? 8'h47 : 8'(c ^ 8'h38));
      bd_write(14'h2000 + 14'(c), 8'(8'hF0 ^ c));
      bd_write(14'h3800 + 14'(c), 8'(8'h0F + c));
    end
    bd_write(14'h1234, 8'h9E);
    bd_write(14'h0100, 8'h11);
    bd_write(14'h0155, 8'h66);
    check("rst_held_pix_load", 32'(pix_load), 32'd0);

    // Release at the start of the frame: first strobe after the edge sampling hc=3.
    hc = 9'd0; vc = 9'd0;
    #1;
    rst = 1'b0;
    #1;
    repeat (3) tick();
    check("first_pix_early", 32'(pix_load), 32'd0);
    tick();
    check("first_pix_load", 32'(pix_load), 32'd1);
    check("first_pix_hc", 32'(last_hc), 32'd3);
    check("first_bitmap", 32'(bitmap_byte), 32'hAA);
    check("first_attr", 32'(attr_byte), 32'h47);

    // Read requested on a display phase: two stall clocks, issue at 10, ack at 11.
    while (hc != 9'd8) tick();
    cpu_access(1'b0, 13'h1234, 8'h00);
    check("t3_ack_hc", 32'(ack_hc), 32'd11);

    // Write outside the window: no stall, then read it back.
    while (hc != 9'd300) tick();
    cpu_access(1'b1, 13'h0100, 8'h5A);
    check("t4_ack_hc", 32'(ack_hc), 32'd301);
    cpu_access(1'b0, 13'h0100, 8'h00);

    // Reset while a write is in its data cycle: no ack, memory untouched.
    acks_before = n_acks;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0155; cpu_din = 8'hC3;
    #1;
    tick();
    check("abort_we_pending", 32'(vram_we), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we_cleared", 32'(vram_we), 32'd0);
    cpu_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    repeat (2) tick();
    check("abort_no_ack", 32'(n_acks), 32'(acks_before));
    cpu_access(1'b0, 13'h0155, 8'h00);

    // Back-to-back reads across a whole line while the display keeps fetching.
    while (hc != 9'd0) tick();
    pix_before  = n_pix;
    acks_before = n_acks;
    k = 0;
    while (hc < 9'd280) begin
      cpu_access(1'b0, (k % 2 == 1) ? 13'h1234 : 13'h0100, 8'h00);
      k++;
    end
    check("t5_pix_count", 32'(n_pix - pix_before), 32'd32);
    check("t5_ack_count", 32'(n_acks - acks_before), 32'(k));

    // Page 1: display addresses carry bit 13.
    while (hc != 9'd0) tick();
    page = 1'b1;
    #1;
    pix_before = n_pix;
    tick();
    check("p1_bmp_addr", 32'(vram_addr), 32'h2000);
    tick();
    check("p1_attr_addr", 32'(vram_addr), 32'h3800);
    while (hc < 9'd280) tick();
    check("p1_pix_count", 32'(n_pix - pix_before), 32'd32);
    page = 1'b0;
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
